ex_unit_mc: RTL and testbench
=============================

# ex_unit_mc

Parametrised, multi-cycle successor to the single-cycle execute stage. It does three things:
- Computes ALU results and memory effective addresses at configurable data width.
- Adds an iterative shift-add multiplier.
- Keeps the NVZ flag register, with per-opcode write masks.

It sits between decode and memory stages, with valid/ready handshakes on both sides and a one-entry output register so that downstream back-pressure stalls the block cleanly.

## Interface
- `W`, 16, datapath width in bits (≥4).
- `CNT_W`, `$clog2(W+1)`, multiplier iteration counter width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `flush`  in  1  synchronous kill of in-flight op and output register.
- `in_valid`  in  1  operands/control valid.
- `in_ready`  out  1  block accepts this cycle.
- `aluop`  in  4  opcode (see Operation).
- `alusrc`, `memenable`, `pcread`  in  1 each  immediate select, memory-address mode, PC-read op.
- `branch`  in  2  nonzero = branch op.
- `src1`, `src2`, `imm`  in  W each  operands.
- `out_valid`  out  1  result register holds valid data.
- `out_ready`  in  1  downstream consumes.
- `result`  out  W  registered result.
- `flags`  out  3  registered {N,V,Z}.

## Operation
- Operand select:
  - `a = memenable ? src1 & ~1 : src1`.
  - `b = alusrc ? (memenable ? imm<<1 : imm) : src2`.
  - Shifts drop bits beyond W.
- Opcodes:
  - 0 ADD.
  - 1 SUB (a−b).
  - 2 XOR.
  - 3 AND.
  - 4 SLL by b[CNT_W−1:0].
  - 5 SRA by b[CNT_W−1:0].
  - 6 ROR by b[CNT_W−1:0].
  - 7 MUL (low W bits of a·b, multi-cycle).
  - 8–15 reserved: result 0, flags unchanged.
- Shift amounts ≥W: SLL → 0; SRA → all sign bits; ROR uses amount mod W.
- ADD/SUB wrap modulo 2^W. V = signed two's-complement overflow of the wrapped result.
- Flag write mask:
  - ADD/SUB write N,V,Z.
  - Opcodes 2–6 write Z only.
  - MUL writes N,Z. V is left unchanged.
- Flags are never written when `branch != 0` or `pcread == 1`. The result is still produced.
- Z = (result == 0). N = result[W−1].
- FSM states and transitions:
  - IDLE → IDLE on accept of a single-cycle op.
  - IDLE → MUL on accept of MUL. The counter is loaded with W; a and b are latched.
  - MUL: one shift-add iteration per cycle; counter decrements. MUL → IDLE when the counter reaches 0, loading the product into `result`.
- `in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush`.
- Accept = `in_valid && in_ready`.
- The result register and flags load only when a result completes.
- The result register loads even if `out_ready` was low at accept time; the ready term above guarantees the register is free.
- `out_valid` clears on `out_valid && out_ready` unless a new result loads in the same cycle, in which case it stays 1.
- `flush` behaviour:
  - Returns FSM to IDLE and clears `out_valid`.
  - Discards any partial product; `flags` are not modified.
  - Wins over accept and completion in the same cycle.

## Timing
- Reset values:
  - `out_valid` = 0, `result` = 0, `flags` = 3'b000.
  - FSM = IDLE, counter = 0.
  - `in_ready` = 1 once `rst` deasserts (combinational from state).
- Single-cycle ops: accepted at edge k; `result`, `flags` and `out_valid` are updated at edge k+1.
- MUL: accepted at edge k; iterations at edges k+1..k+W; result and flags at edge k+W; `out_valid` visible after edge k+W. Latency is W cycles; `in_ready` = 0 in between.
- Back-to-back single-cycle ops sustain 1 op/cycle while `out_ready` = 1.
- With `out_ready` = 0 and `out_valid` = 1, `in_ready` = 0. The result is held stable until consumed.
- Reset mid-MUL: everything returns to reset values immediately (asynchronous).

## Structure
- Package `ex_pkg`:
  - opcode localparams (OP_ADD…OP_MUL);
  - flag bit indices (FLAG_N=2, FLAG_V=1, FLAG_Z=0);
  - FSM state encoding;
  - a function returning the 3-bit flag write mask per opcode.
- Sub-module `mul_iter` (parameter W):
  - ports: start, a, b, busy, done, product;
  - owns the counter and the shift-add datapath.
- The single-cycle ALU and flag logic stay in `ex_unit_mc`.

## Test plan
- W=16, ADD 0x7FFF+0x0001, `out_ready` = 1 → result 0x8000 after 1 cycle; flags N=1, V=1, Z=0.
- SUB 5−5 with `branch` = 2'b01 after a prior flag state of 3'b110 → result 0x0000; flags stay 3'b110.
- MUL 0x0012·0x0034 → `in_ready` low for 16 cycles; result 0x03A8 at edge k+16; Z=0, N=0; V unchanged.
- Memory mode: `memenable` = 1, `alusrc` = 1, `src1` = 0x1003, `imm` = 0x0004, ADD → result 0x100A.
- Back-pressure: 3 ADDs issued while `out_ready` = 0 → only the first is accepted; result holds; accepts resume one per cycle after `out_ready` = 1.
- `flush` asserted at iteration 7 of a MUL → `out_valid` stays 0, flags unchanged, `in_ready` = 1 next cycle; async `rst` mid-MUL → all outputs go to reset values without a clock edge.

Source files
------------

// File: rtl/ex_unit_mc_pkg.sv
// Shared opcode, flag-index and FSM definitions for the multi-cycle execute stage.
// Also provides the per-opcode flag write mask used when a result completes.
package ex_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Bit order follows {N,V,Z}; reserved opcodes write nothing.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    case (op)
      OP_ADD, OP_SUB:                         m = 3'b111;
      OP_XOR, OP_AND, OP_SLL, OP_SRA, OP_ROR: m = 3'b001;
      OP_MUL:                                 m = 3'b101;
      default:                                m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_unit_mc_mul_iter.sv
// Shift-add multiplier, one iteration per cycle; product valid with done after W iterations.
// No backpressure: the caller only starts it when its output register is free; flush abandons the op.
module mul_iter
  import ex_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     acc_nxt;

  always_comb begin
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (flush) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d    = CNT_W'(W);
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
    end else if (busy) begin
      cnt_d    = cnt_q - CNT_W'(1);
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // The final iteration's sum is exposed combinationally so it lands on the same edge the counter hits 0.
  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CNT_W'(1));
  assign product = acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/ex_unit_mc.sv
// Execute stage: single-cycle ALU (1-cycle latency) plus iterative MUL (W cycles), NVZ flags.
// Backpressure: in_ready drops while MUL runs or the one-entry output register is held by out_ready=0.
module ex_unit_mc
  import ex_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   aluop,
  input  logic         alusrc,
  input  logic         memenable,
  input  logic         pcread,
  input  logic [1:0]   branch,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  input  logic [W-1:0] imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  state_t           state_q, state_d;
  logic             out_vld_q, out_vld_d;
  logic [W-1:0]     result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic             mul_wr_q, mul_wr_d;

  logic [W-1:0]     a_op, b_op, alu_res, sum, diff, ld_res, mul_prod;
  logic [CNT_W-1:0] shamt, rot_amt, rot_inv;
  logic             alu_v, ld, ld_v, accept, mul_start, flag_wr_en, mul_busy, mul_done;
  logic [2:0]       ld_mask;

  always_comb begin
    a_op    = memenable ? (src1 & ~W'(1)) : src1;
    b_op    = alusrc ? (memenable ? (imm << 1) : imm) : src2;
    shamt   = b_op[CNT_W-1:0];
    rot_amt = shamt % CNT_W'(W);
    rot_inv = CNT_W'(W) - rot_amt;
    sum     = a_op + b_op;
    diff    = a_op - b_op;
    alu_res = '0;
    alu_v   = 1'b0;
    case (aluop)
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (a_op[W-1] == b_op[W-1]) && (sum[W-1] != a_op[W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (a_op[W-1] != b_op[W-1]) && (diff[W-1] != a_op[W-1]);
      end
      OP_XOR: alu_res = a_op ^ b_op;
      OP_AND: alu_res = a_op & b_op;
      OP_SLL: alu_res = a_op << shamt;
      OP_SRA: alu_res = $signed(a_op) >>> shamt;
      OP_ROR: alu_res = (a_op >> rot_amt) | (a_op << rot_inv);
      default: alu_res = '0;
    endcase
  end

  mul_iter #(.W(W), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .start   (mul_start),
    .a       (a_op),
    .b       (b_op),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    in_ready   = (state_q == ST_IDLE) && (!out_vld_q || out_ready) && !flush;
    accept     = in_valid && in_ready;
    mul_start  = accept && (aluop == OP_MUL);
    flag_wr_en = (branch == 2'b00) && !pcread;

    state_d   = state_q;
    mul_wr_d  = mul_wr_q;
    out_vld_d = out_vld_q && !out_ready;
    result_d  = result_q;
    flags_d   = flags_q;
    ld        = 1'b0;
    ld_res    = '0;
    ld_v      = 1'b0;
    ld_mask   = 3'b000;

    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done || !mul_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // MUL must remember at accept time whether it may touch the flags.
    if (mul_start) mul_wr_d = flag_wr_en;

    if (accept && (aluop != OP_MUL)) begin
      ld      = 1'b1;
      ld_res  = alu_res;
      ld_v    = alu_v;
      ld_mask = flag_wr_en ? flag_mask(aluop) : 3'b000;
    end else if ((state_q == ST_MUL) && mul_done) begin
      ld      = 1'b1;
      ld_res  = mul_prod;
      ld_mask = mul_wr_q ? flag_mask(OP_MUL) : 3'b000;
    end

    if (ld) begin
      out_vld_d = 1'b1;
      result_d  = ld_res;
      if (ld_mask[FLAG_N]) flags_d[FLAG_N] = ld_res[W-1];
      if (ld_mask[FLAG_V]) flags_d[FLAG_V] = ld_v;
      if (ld_mask[FLAG_Z]) flags_d[FLAG_Z] = (ld_res == '0);
    end

    if (flush) begin
      state_d   = ST_IDLE;
      out_vld_d = 1'b0;
      result_d  = result_q;
      flags_d   = flags_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      out_vld_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= 3'b000;
      mul_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= out_vld_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      mul_wr_q  <= mul_wr_d;
    end
  end

  assign out_valid = out_vld_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_ex_unit_mc.sv
// Bench for ex_unit_mc: directed vectors, a transaction-level reference model checked every cycle,
// and hand-computed literal expectations for the key cases.
module tb_ex_unit_mc;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   aluop = 4'd0;
  logic         alusrc = 1'b0;
  logic         memenable = 1'b0;
  logic         pcread = 1'b0;
  logic [1:0]   branch = 2'b00;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic [W-1:0] imm = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [2:0]   flags;

  int n_chk  = 0;
  int n_pass = 0;
  logic tb_done = 1'b0;

  always #5 clk = ~clk;

  ex_unit_mc #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .alusrc    (alusrc),
    .memenable (memenable),
    .pcread    (pcread),
    .branch    (branch),
    .src1      (src1),
    .src2      (src2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a transaction view of the block (remaining MUL cycles, held result, flags).
  int           m_busy;
  logic         m_vld;
  logic [W-1:0] m_res;
  logic [W-1:0] m_pend;
  logic [2:0]   m_flags;
  logic         m_pend_wr;
  logic         m_rdy;

  assign m_rdy = (m_busy == 0) && (!m_vld || out_ready) && !flush;

  function automatic void m_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic v);
    int     sa, sb, s, sh;
    longint p;
    logic [2*W-1:0] dbl;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[4:0]);
    r  = '0;
    v  = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; v = (s >= (1 << (W-1))) || (s < -(1 << (W-1))); r = s[W-1:0]; end
      4'd1: begin s = sa - sb; v = (s >= (1 << (W-1))) || (s < -(1 << (W-1))); r = s[W-1:0]; end
      4'd2: r = a ^ b;
      4'd3: r = a & b;
      4'd4: r = (sh >= W) ? '0 : (a << sh);
      4'd5: begin s = sa >>> sh; r = s[W-1:0]; end
      4'd6: begin dbl = {a, a}; dbl = dbl >> (sh % W); r = dbl[W-1:0]; end
      4'd7: begin p = longint'(a) * longint'(b); r = p[W-1:0]; end
      default: r = '0;
    endcase
  endfunction

  function automatic logic [2:0] m_upd(input logic [2:0] old, input logic [W-1:0] r, input logic v,
                                       input logic [2:0] mask);
    logic [2:0] f;
    f = old;
    if (mask[2]) f[2] = r[W-1];
    if (mask[1]) f[1] = v;
    if (mask[0]) f[0] = (r == '0);
    return f;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic         take, wr, v;
    logic [W-1:0] a, b, r;
    logic [2:0]   mask;
    if (rst) begin
      m_busy = 0; m_vld = 1'b0; m_res = '0; m_pend = '0; m_flags = 3'b000; m_pend_wr = 1'b0;
    end else if (flush) begin
      m_busy = 0;
      m_vld  = 1'b0;
    end else begin
      take = in_valid && m_rdy;
      if (out_ready) m_vld = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_res   = m_pend;
          m_flags = m_upd(m_flags, m_pend, 1'b0, m_pend_wr ? 3'b101 : 3'b000);
          m_vld   = 1'b1;
        end
      end
      if (take) begin
        a  = memenable ? (src1 & ~W'(1)) : src1;
        b  = alusrc ? (memenable ? (imm << 1) : imm) : src2;
        wr = (branch == 2'b00) && !pcread;
        m_alu(aluop, a, b, r, v);
        if (aluop == 4'd7) begin
          m_busy = W; m_pend = r; m_pend_wr = wr;
        end else begin
          case (aluop)
            4'd0, 4'd1:                   mask = 3'b111;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6: mask = 3'b001;
            default:                      mask = 3'b000;
          endcase
          m_res   = r;
          m_flags = m_upd(m_flags, r, v, wr ? mask : 3'b000);
          m_vld   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !tb_done) begin
      check("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
      check("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_vld});
      check("cyc_result", {16'd0, result}, {16'd0, m_res});
      check("cyc_flags", {29'd0, flags}, {29'd0, m_flags});
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] s1, input logic [W-1:0] s2,
                       input logic [W-1:0] im, input logic as, input logic me, input logic pr,
                       input logic [1:0] br, output int waited);
    logic got;
    aluop = op; src1 = s1; src2 = s2; imm = im;
    alusrc = as; memenable = me; pcread = pr; branch = br;
    in_valid = 1'b1;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 50) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #2;
      waited++;
    end
    if (!got) begin
      n_chk++;
      $display("FAIL accept_timeout: op %0d never accepted within %0d cycles", op, waited);
    end
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] r, input logic [2:0] f);
    check({name, "_result"}, {16'd0, result}, {16'd0, r});
    check({name, "_flags"}, {29'd0, flags}, {29'd0, f});
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int w, busy_cnt;
    #1;
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {29'd0, flags}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    #11 rst = 1'b0;
    #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;

    issue(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("add_ovf", 16'h8000, 3'b110);
    issue(4'd1, 16'h0005, 16'h0005, 16'h0000, 0, 0, 0, 2'b01, w);
    expect_out("sub_branch", 16'h0000, 3'b110);

    issue(4'd7, 16'h0012, 16'h0034, 16'h0000, 0, 0, 0, 2'b00, w);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) break;
      busy_cnt++;
    end
    check("mul_busy_cycles", busy_cnt, 32'd16);
    expect_out("mul", 16'h03A8, 3'b010);
    @(posedge clk); #2;

    issue(4'd0, 16'h1003, 16'h0000, 16'h0004, 1, 1, 0, 2'b00, w);
    expect_out("mem_addr", 16'h100A, 3'b000);
    issue(4'd2, 16'hA5A5, 16'h5A5A, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("xor", 16'hFFFF, 3'b000);
    issue(4'd3, 16'hF0F0, 16'h0FF0, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("and", 16'h00F0, 3'b000);
    issue(4'd5, 16'h8000, 16'h0014, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("sra_big", 16'hFFFF, 3'b000);
    issue(4'd6, 16'h0001, 16'h0011, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("ror_mod", 16'h8000, 3'b000);
    issue(4'd4, 16'h0001, 16'h0010, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("sll_big", 16'h0000, 3'b001);
    issue(4'd9, 16'h1234, 16'h5678, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("reserved", 16'h0000, 3'b001);
    issue(4'd0, 16'h0001, 16'h0001, 16'h0000, 0, 0, 1, 2'b00, w);
    expect_out("pcread", 16'h0002, 3'b001);
    issue(4'd1, 16'h8000, 16'h0001, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("sub_ovf", 16'h7FFF, 3'b010);
    cyc(1);

    issue(4'd7, 16'h0003, 16'h0005, 16'h0000, 0, 0, 0, 2'b00, w);
    repeat (6) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_flags", {29'd0, flags}, 32'b010);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    cyc(W + 2);
    check("flush_no_late_result", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    issue(4'd0, 16'h0001, 16'h0002, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("bp_first", 16'h0003, 3'b000);
    aluop = 4'd0; src1 = 16'h0003; src2 = 16'h0004; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold", {16'd0, result}, 32'h0003);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    issue(4'd0, 16'h0003, 16'h0004, 16'h0000, 0, 0, 0, 2'b00, w);
    check("bp_resume_wait", w, 32'd1);
    expect_out("bp_second", 16'h0007, 3'b000);
    issue(4'd0, 16'h0005, 16'h0006, 16'h0000, 0, 0, 0, 2'b00, w);
    check("bp_b2b_wait", w, 32'd1);
    expect_out("bp_third", 16'h000B, 3'b000);

    issue(4'd7, 16'h0007, 16'h0009, 16'h0000, 0, 0, 0, 2'b00, w);
    cyc(3);
    #1 rst = 1'b1;
    #1;
    check("arst_result", {16'd0, result}, 32'd0);
    check("arst_flags", {29'd0, flags}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    issue(4'd0, 16'h0002, 16'h0002, 16'h0000, 0, 0, 0, 2'b00, w);
    expect_out("post_rst", 16'h0004, 3'b000);
    cyc(2);

    tb_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
